// File: rtl/kinrow_game_engine_if.sv
// Move/result bundle between the game engine and the surrounding game top.
// N must match the engine instance so position and board widths agree.
interface kinrow_game_engine_if #(
  parameter int N = 3
);
  localparam int POS_W = $clog2(N * N);

  logic               play;
  logic               new_game;
  logic [POS_W-1:0]   player1_position;
  logic [POS_W-1:0]   player2_position;
  logic [2*N*N-1:0]   board;
  logic [1:0]         who;
  logic               turn;
  logic               busy;
  logic               game_over;
  logic               move_err;

  modport master (
    output play, new_game, player1_position, player2_position,
    input  board, who, turn, busy, game_over, move_err
  );

  modport slave (
    input  play, new_game, player1_position, player2_position,
    output board, who, turn, busy, game_over, move_err
  );
endinterface

// File: rtl/kinrow_game_engine.sv
// N x N, K-in-a-row two-player engine with a four-cycle incremental win check.
// Define ALTERNATE_START_EN to alternate the opening player on every new_game.
module kinrow_game_engine #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic               clock,
  input  logic               reset,
  kinrow_game_engine_if.slave io
);
  localparam int CELLS = N * N;
  localparam int POS_W = $clog2(CELLS);
  localparam int CNT_W = $clog2(CELLS + 1);

  typedef enum logic [1:0] {WAIT_P1, WAIT_P2, CHECK, OVER} state_t;

  state_t                  state_q, state_d;
  logic [CELLS-1:0][1:0]   cells_q, cells_d;
  logic [1:0]              who_q, who_d;
  logic                    turn_q, turn_d;
  logic                    busy_q, busy_d;
  logic                    over_q, over_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    plyr_q, plyr_d;
  logic [1:0]              dir_q, dir_d;
  logic                    hit_q, hit_d;

  logic                    ng_start;
  logic [POS_W-1:0]        mv_pos;
  logic                    mv_legal;
  logic                    mv_p2;
  logic                    dir_hit;
  logic                    hit_now;
  int                      chk_row, chk_col, dr, dc, run;

  // Off-board coordinates read as empty, which clips runs at the edges.
  function automatic logic [1:0] cell_at(input int r, input int c);
    if (r < 0 || r >= N || c < 0 || c >= N) return 2'b00;
    return cells_q[POS_W'(r * N + c)];
  endfunction

  function automatic int side_run(input int r, input int c, input int sr, input int sc,
                                  input logic [1:0] code);
    int   n;
    logic go;
    n  = 0;
    go = 1'b1;
    for (int i = 1; i < K; i++) begin
      if (go && cell_at(r + i * sr, c + i * sc) == code) n++;
      else go = 1'b0;
    end
    return n;
  endfunction

`ifdef ALTERNATE_START_EN
  logic start_q, start_d;

  always_comb start_d = io.new_game ? ~start_q : start_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) start_q <= 1'b0;
    else        start_q <= start_d;
  end

  assign ng_start = ~start_q;
`else
  assign ng_start = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cells_d = cells_q;
    who_d   = who_q;
    turn_d  = turn_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    plyr_d  = plyr_q;
    dir_d   = dir_q;
    hit_d   = hit_q;
    hit_now = hit_q;

    mv_p2    = (state_q == WAIT_P2);
    mv_pos   = mv_p2 ? io.player2_position : io.player1_position;
    mv_legal = (int'(mv_pos) < CELLS) &&
               (cell_at(int'(mv_pos) / N, int'(mv_pos) % N) == 2'b00);

    chk_row = int'(pos_q) / N;
    chk_col = int'(pos_q) % N;
    case (dir_q)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    run = 1 + side_run(chk_row, chk_col, dr, dc, {plyr_q, ~plyr_q})
            + side_run(chk_row, chk_col, -dr, -dc, {plyr_q, ~plyr_q});
    dir_hit = (run >= K);

    if (io.new_game) begin
      cells_d = '0;
      who_d   = 2'b00;
      cnt_d   = '0;
      hit_d   = 1'b0;
      dir_d   = 2'd0;
      turn_d  = ng_start;
      state_d = ng_start ? WAIT_P2 : WAIT_P1;
    end else begin
      case (state_q)
        WAIT_P1, WAIT_P2: begin
          if (io.play) begin
            if (mv_legal) begin
              cells_d[mv_pos] = {mv_p2, ~mv_p2};
              cnt_d   = cnt_q + CNT_W'(1);
              pos_d   = mv_pos;
              plyr_d  = mv_p2;
              dir_d   = 2'd0;
              hit_d   = 1'b0;
              state_d = CHECK;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        CHECK: begin
          hit_now = hit_q | dir_hit;
          hit_d   = hit_now;
          dir_d   = dir_q + 2'd1;
          // Anti-diagonal is the last direction; decide the outcome here.
          if (dir_q == 2'd3) begin
            if (hit_now) begin
              who_d   = {plyr_q, ~plyr_q};
              state_d = OVER;
            end else if (cnt_q == CNT_W'(CELLS)) begin
              who_d   = 2'b11;
              state_d = OVER;
            end else begin
              turn_d  = ~plyr_q;
              state_d = plyr_q ? WAIT_P1 : WAIT_P2;
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == CHECK);
    over_d = (state_d == OVER);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= WAIT_P1;
      cells_q <= '0;
      who_q   <= 2'b00;
      turn_q  <= 1'b0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      pos_q   <= '0;
      plyr_q  <= 1'b0;
      dir_q   <= 2'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cells_q <= cells_d;
      who_q   <= who_d;
      turn_q  <= turn_d;
      busy_q  <= busy_d;
      over_q  <= over_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      plyr_q  <= plyr_d;
      dir_q   <= dir_d;
      hit_q   <= hit_d;
    end
  end

  assign io.board     = cells_q;
  assign io.who       = who_q;
  assign io.turn      = turn_q;
  assign io.busy      = busy_q;
  assign io.game_over = over_q;
  assign io.move_err  = err_q;
endmodule

// File: tb/tb_kinrow_game_engine.sv
// Scoreboard bench for kinrow_game_engine: a 3x3/K=3 and a 5x5/K=4 instance,
// directed moves push expected outcomes, per-instance monitors pop and compare.
module tb_kinrow_game_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef ALTERNATE_START_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  kinrow_game_engine_if #(.N(3)) a_if();
  kinrow_game_engine_if #(.N(5)) b_if();

  kinrow_game_engine #(.N(3), .K(3)) dut_a (.clock(clk), .reset(rst_n), .io(a_if.slave));
  kinrow_game_engine #(.N(5), .K(4)) dut_b (.clock(clk), .reset(rst_n), .io(b_if.slave));

  typedef struct {
    bit          err;
    logic [1:0]  who;
    bit          go;
    bit          turn;
    logic [63:0] board;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] model_a = '0;
  logic [63:0] model_b = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_event(input string tag, input exp_t e, input bit is_err, input int blen,
                           input logic [1:0] who, input logic go, input logic turn,
                           input logic [63:0] board);
    chk({tag, "_kind"}, 64'(is_err), 64'(e.err));
    if (!is_err) begin
      chk({tag, "_busy_len"}, 64'(blen), 64'd4);
      chk({tag, "_who"}, 64'(who), 64'(e.who));
      chk({tag, "_game_over"}, 64'(go), 64'(e.go));
    end
    chk({tag, "_turn"}, 64'(turn), 64'(e.turn));
    chk({tag, "_board"}, board, e.board);
  endtask

  initial begin : mon_a
    int   blen = 0;
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
        prev = 1'b0;
      end else begin
        if (a_if.move_err) begin
          chk("a_err_expected", 64'(qa.size() > 0), 64'd1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp_event("a_err", e, 1'b1, 0, a_if.who, a_if.game_over, a_if.turn, 64'(a_if.board));
          end
        end
        if (a_if.busy) blen++;
        else if (prev) begin
          chk("a_done_expected", 64'(qa.size() > 0), 64'd1);
          if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp_event("a_done", e, 1'b0, blen, a_if.who, a_if.game_over, a_if.turn, 64'(a_if.board));
          end
          blen = 0;
        end
        prev = a_if.busy;
      end
    end
  end

  initial begin : mon_b
    int   blen = 0;
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        blen = 0;
        prev = 1'b0;
      end else begin
        if (b_if.move_err) begin
          chk("b_err_expected", 64'(qb.size() > 0), 64'd1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp_event("b_err", e, 1'b1, 0, b_if.who, b_if.game_over, b_if.turn, 64'(b_if.board));
          end
        end
        if (b_if.busy) blen++;
        else if (prev) begin
          chk("b_done_expected", 64'(qb.size() > 0), 64'd1);
          if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp_event("b_done", e, 1'b0, blen, b_if.who, b_if.game_over, b_if.turn, 64'(b_if.board));
          end
          blen = 0;
        end
        prev = b_if.busy;
      end
    end
  end

  // sel 0 = 3x3 instance, 1 = 5x5 instance; the idle player's input carries a decoy.
  task automatic mv(input bit sel, input int p, input bit p2, input bit err,
                    input logic [1:0] who, input bit go, input bit turn);
    exp_t e;
    if (!sel) begin
      if (!err) model_a[2*p +: 2] = p2 ? 2'b10 : 2'b01;
      e = '{err, who, go, turn, model_a};
      qa.push_back(e);
    end else begin
      if (!err) model_b[2*p +: 2] = p2 ? 2'b10 : 2'b01;
      e = '{err, who, go, turn, model_b};
      qb.push_back(e);
    end
    @(posedge clk); #1;
    if (!sel) begin
      a_if.play = 1'b1;
      a_if.player1_position = p2 ? 4'((p + 3) % 9) : 4'(p);
      a_if.player2_position = p2 ? 4'(p) : 4'((p + 3) % 9);
    end else begin
      b_if.play = 1'b1;
      b_if.player1_position = p2 ? 5'((p + 3) % 25) : 5'(p);
      b_if.player2_position = p2 ? 5'(p) : 5'((p + 3) % 25);
    end
    @(posedge clk); #1;
    a_if.play = 1'b0;
    b_if.play = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n   = 1'b0;
    model_a = '0;
    model_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    a_if.play = 1'b0; a_if.new_game = 1'b0;
    a_if.player1_position = '0; a_if.player2_position = '0;
    b_if.play = 1'b0; b_if.new_game = 1'b0;
    b_if.player1_position = '0; b_if.player2_position = '0;
    #3;
    chk("rst_board", 64'(a_if.board), 64'd0);
    chk("rst_who", 64'(a_if.who), 64'd0);
    chk("rst_turn", 64'(a_if.turn), 64'd0);
    chk("rst_busy", 64'(a_if.busy), 64'd0);
    chk("rst_game_over", 64'(a_if.game_over), 64'd0);
    chk("rst_move_err", 64'(a_if.move_err), 64'd0);
    chk("rst_b_board", 64'(b_if.board), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // P1 completes the middle row
    mv(0, 4, 0, 0, 2'b00, 0, 1);
    mv(0, 0, 1, 0, 2'b00, 0, 0);
    mv(0, 3, 0, 0, 2'b00, 0, 1);
    mv(0, 1, 1, 0, 2'b00, 0, 0);
    mv(0, 5, 0, 0, 2'b01, 1, 0);
    chk("row_win_cells", 64'(a_if.board[11:6]), 64'b010101);
    chk("row_win_over", 64'(a_if.game_over), 64'd1);

    // occupied cell and off-board position are rejected
    do_reset();
    mv(0, 4, 0, 0, 2'b00, 0, 1);
    mv(0, 4, 1, 1, 2'b00, 0, 1);
    mv(0, 9, 1, 1, 2'b00, 0, 1);
    mv(0, 0, 1, 0, 2'b00, 0, 0);

    // full board with no line -> draw
    do_reset();
    mv(0, 0, 0, 0, 2'b00, 0, 1);
    mv(0, 1, 1, 0, 2'b00, 0, 0);
    mv(0, 2, 0, 0, 2'b00, 0, 1);
    mv(0, 4, 1, 0, 2'b00, 0, 0);
    mv(0, 3, 0, 0, 2'b00, 0, 1);
    mv(0, 5, 1, 0, 2'b00, 0, 0);
    mv(0, 7, 0, 0, 2'b00, 0, 1);
    mv(0, 6, 1, 0, 2'b00, 0, 0);
    mv(0, 8, 0, 0, 2'b11, 1, 0);
    @(posedge clk); #1;
    a_if.play = 1'b1; a_if.player1_position = 4'd0; a_if.player2_position = 4'd9;
    @(posedge clk); #1;
    a_if.play = 1'b0;
    repeat (3) @(posedge clk);
    chk("draw_board", 64'(a_if.board), 64'(18'b010110101001011001));
    chk("draw_who", 64'(a_if.who), 64'd3);
    chk("draw_game_over", 64'(a_if.game_over), 64'd1);

    // asynchronous reset in the middle of CHECK
    do_reset();
    @(posedge clk); #1;
    a_if.play = 1'b1; a_if.player1_position = 4'd0;
    @(posedge clk); #1;
    a_if.play = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_a = '0;
    model_b = '0;
    #1;
    chk("mid_rst_board", 64'(a_if.board), 64'd0);
    chk("mid_rst_busy", 64'(a_if.busy), 64'd0);
    chk("mid_rst_who", 64'(a_if.who), 64'd0);
    chk("mid_rst_turn", 64'(a_if.turn), 64'd0);
    chk("mid_rst_game_over", 64'(a_if.game_over), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mv(0, 2, 0, 0, 2'b00, 0, 1);

    // 5x5, K=4: diagonal win, then a row-wrapping non-win
    do_reset();
    mv(1, 6, 0, 0, 2'b00, 0, 1);
    mv(1, 0, 1, 0, 2'b00, 0, 0);
    mv(1, 12, 0, 0, 2'b00, 0, 1);
    mv(1, 1, 1, 0, 2'b00, 0, 0);
    mv(1, 18, 0, 0, 2'b00, 0, 1);
    mv(1, 2, 1, 0, 2'b00, 0, 0);
    mv(1, 24, 0, 0, 2'b01, 1, 0);
    do_reset();
    mv(1, 3, 0, 0, 2'b00, 0, 1);
    mv(1, 10, 1, 0, 2'b00, 0, 0);
    mv(1, 4, 0, 0, 2'b00, 0, 1);
    mv(1, 11, 1, 0, 2'b00, 0, 0);
    mv(1, 5, 0, 0, 2'b00, 0, 1);
    mv(1, 12, 1, 0, 2'b00, 0, 0);
    mv(1, 6, 0, 0, 2'b00, 0, 1);
    chk("wrap_who", 64'(b_if.who), 64'd0);
    chk("wrap_game_over", 64'(b_if.game_over), 64'd0);

    // new_game restarts; coincident play is ignored
    do_reset();
    mv(0, 4, 0, 0, 2'b00, 0, 1);
    @(posedge clk); #1;
    a_if.new_game = 1'b1; a_if.play = 1'b1;
    a_if.player1_position = 4'd0; a_if.player2_position = 4'd0;
    @(posedge clk); #1;
    a_if.new_game = 1'b0; a_if.play = 1'b0;
    model_a = '0;
    chk("ng1_turn", 64'(a_if.turn), 64'(ALT));
    chk("ng1_board", 64'(a_if.board), 64'd0);
    chk("ng1_who", 64'(a_if.who), 64'd0);
    chk("ng1_move_err", 64'(a_if.move_err), 64'd0);
    @(posedge clk); #1;
    a_if.new_game = 1'b1;
    @(posedge clk); #1;
    a_if.new_game = 1'b0;
    chk("ng2_turn", 64'(a_if.turn), 64'd0);
    mv(0, 0, 0, 0, 2'b00, 0, 1);

    for (int i = 0; i < 20 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
    chk("queue_drained", 64'(qa.size() + qb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
